// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register file slave.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on a
// rising clock edge where VALID and READY are both 1. The source holds VALID and
// its payload stable until that edge; it never waits for READY before raising VALID.
interface axi4_lite_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite slave register file. The low NUM_RW registers are
// read/write and exported to core logic; the top C_NUM_RO registers mirror
// status inputs and are read-only. AW and W each have a one-entry holding
// register so they can arrive in either order; one B response may be outstanding.
module axi4_lite_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS         = 16,
  parameter int C_NUM_RO           = 4
) (
  input  logic                                                S_AXI_ACLK,
  input  logic                                                S_AXI_ARESET,
  axi4_lite_regfile_if.slave                                  s_axi,
  input  logic [C_NUM_RO*C_S_AXI_DATA_WIDTH-1:0]              ro_status_i,
  output logic [(C_NUM_REGS-C_NUM_RO)*C_S_AXI_DATA_WIDTH-1:0] rw_regs_o,
  output logic [C_NUM_REGS-C_NUM_RO-1:0]                      wr_pulse_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = AW - LSB;
  localparam int NUM_RW = C_NUM_REGS - C_NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write-side state
  logic              aw_full_q, aw_full_d;
  logic [AW-1:0]     aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [NUM_RW-1:0] wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]     regs_q [NUM_RW];
  logic [DW-1:0]     regs_d [NUM_RW];

  // Read-side state
  logic              rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  widx, ridx;

  // Address protection bits and sub-lane address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         aw_addr_q[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

  assign aw_hs  = s_axi.S_AXI_AWVALID && !aw_full_q;
  assign w_hs   = s_axi.S_AXI_WVALID && !w_full_q;
  assign ar_hs  = s_axi.S_AXI_ARVALID && !rvalid_q;
  // A held AW/W pair only commits once the previous B has been taken.
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign widx   = aw_addr_q[AW-1:LSB];
  assign ridx   = s_axi.S_AXI_ARADDR[AW-1:LSB];

  // Write path: capture AW/W, decode and commit the held pair, manage B.
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi.S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi.S_AXI_WDATA;
      w_strb_d = s_axi.S_AXI_WSTRB;
    end
    if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (int'(widx) >= C_NUM_REGS) begin
        bresp_d = RESP_DECERR;
      end else if (int'(widx) >= NUM_RW) begin
        bresp_d = RESP_SLVERR;
      end else begin
        // An all-zero strobe still counts as a write: OKAY and a pulse.
        bresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_RW; i++) begin
          if (int'(widx) == i) begin
            wr_pulse_d[i] = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb_q[b]) begin
                regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read path: decode the AR address and hold the response until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      // regs_q is the pre-commit value, so a same-edge write is not visible.
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_DECERR;
      if (int'(ridx) < NUM_RW) begin
        rresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_RW; i++) begin
          if (int'(ridx) == i) rdata_d = regs_q[i];
        end
      end else if (int'(ridx) < C_NUM_REGS) begin
        rresp_d = RESP_OKAY;
        for (int k = 0; k < C_NUM_RO; k++) begin
          if (int'(ridx) == NUM_RW + k) rdata_d = ro_status_i[k*DW +: DW];
        end
      end
    end
  end

  // State registers; reset discards held AW/W and any pending response.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign s_axi.S_AXI_AWREADY = !aw_full_q;
  assign s_axi.S_AXI_WREADY  = !w_full_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = !rvalid_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign wr_pulse_o          = wr_pulse_q;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_regs_o[g*DW +: DW] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: stimulus tasks push expected B/R
// responses into queues; a negedge monitor pops and compares on each handshake.
module tb_axi4_lite_regfile;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NRO = 4;
  localparam int NRW = 12;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_lite_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  logic [NRO*DW-1:0] ro_status;
  logic [NRW*DW-1:0] rw_regs;
  logic [NRW-1:0]    wr_pulse;

  axi4_lite_regfile dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus.slave),
    .ro_status_i  (ro_status),
    .rw_regs_o    (rw_regs),
    .wr_pulse_o   (wr_pulse)
  );

  // Scoreboard
  logic [1:0]    exp_b_q[$];
  logic [DW+1:0] exp_r_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Monitor: a valid&&ready seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
        if (exp_b_q.size() == 0) timeout_fail("b_unexpected");
        else check("bresp", 64'(bus.S_AXI_BRESP), 64'(exp_b_q.pop_front()));
      end
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (exp_r_q.size() == 0) timeout_fail("r_unexpected");
        else check("rresp_rdata", 64'({bus.S_AXI_RRESP, bus.S_AXI_RDATA}),
                   64'(exp_r_q.pop_front()));
      end
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1 after the handshake edge.
  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    while (!bus.S_AXI_AWREADY && n < 100) begin @(negedge clk); n++; end
    if (!bus.S_AXI_AWREADY) timeout_fail("aw_handshake");
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int n = 0;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = s;
    bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    while (!bus.S_AXI_WREADY && n < 100) begin @(negedge clk); n++; end
    if (!bus.S_AXI_WREADY) timeout_fail("w_handshake");
    @(posedge clk); #1;
    bus.S_AXI_WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    while (!bus.S_AXI_ARREADY && n < 100) begin @(negedge clk); n++; end
    if (!bus.S_AXI_ARREADY) timeout_fail("ar_handshake");
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input logic [1:0] resp);
    exp_b_q.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
    exp_r_q.push_back({resp, d});
    send_ar(a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      timeout_fail("drain_responses");
      exp_b_q.delete();
      exp_r_q.delete();
    end
  endtask

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Directed stimulus
  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    ro_status = {32'h3333_CCCC, 32'h2222_BBBB, 32'h1111_AAAA, 32'hDEAD_BEEF};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_awready", 64'(bus.S_AXI_AWREADY), 1);
    check("rst_wready", 64'(bus.S_AXI_WREADY), 1);
    check("rst_arready", 64'(bus.S_AXI_ARREADY), 1);
    check("rst_bvalid", 64'(bus.S_AXI_BVALID), 0);
    check("rst_rvalid", 64'(bus.S_AXI_RVALID), 0);
    check("rst_bresp", 64'(bus.S_AXI_BRESP), 0);
    check("rst_rresp", 64'(bus.S_AXI_RRESP), 0);
    check("rst_rdata", 64'(bus.S_AXI_RDATA), 0);
    check("rst_wr_pulse", 64'(wr_pulse), 0);
    check("rst_rw_regs_lo", rw_regs[63:0], 0);
    @(posedge clk); #1;

    // T1: AW+W same cycle, B and pulse one edge after the handshake edge
    do_write(8'h04, 32'hA5A5_1234, 4'hF, OKAY);
    check("t1_bvalid_early", 64'(bus.S_AXI_BVALID), 0);
    check("t1_pulse_early", 64'(wr_pulse), 0);
    @(posedge clk); #1;
    check("t1_bvalid", 64'(bus.S_AXI_BVALID), 1);
    check("t1_pulse", 64'(wr_pulse), 64'h002);
    check("t1_reg1", 64'(rw_regs[1*DW +: DW]), 64'hA5A5_1234);
    @(posedge clk); #1;
    check("t1_pulse_end", 64'(wr_pulse), 0);
    check("t1_bvalid_end", 64'(bus.S_AXI_BVALID), 0);
    do_read(8'h04, 32'hA5A5_1234, OKAY);
    do_read(8'h07, 32'hA5A5_1234, OKAY);
    wait_idle();

    // Zero strobe: OKAY and a pulse, contents untouched
    do_write(8'h04, 32'hFFFF_FFFF, 4'h0, OKAY);
    @(posedge clk); #1;
    check("zs_pulse", 64'(wr_pulse), 64'h002);
    wait_idle();
    do_read(8'h04, 32'hA5A5_1234, OKAY);
    wait_idle();

    // T2: W well ahead of AW, partial strobe
    do_write(8'h08, 32'h1122_3344, 4'hF, OKAY);
    wait_idle();
    exp_b_q.push_back(OKAY);
    send_w(32'h0000_00FF, 4'h1);
    repeat (3) begin
      @(negedge clk);
      check("t2_wready_held", 64'(bus.S_AXI_WREADY), 0);
      check("t2_no_b", 64'(bus.S_AXI_BVALID), 0);
      @(posedge clk); #1;
    end
    send_aw(8'h08);
    check("t2_wready_pre_commit", 64'(bus.S_AXI_WREADY), 0);
    @(posedge clk); #1;
    check("t2_wready_after", 64'(bus.S_AXI_WREADY), 1);
    wait_idle();
    do_read(8'h08, 32'h1122_33FF, OKAY);
    wait_idle();

    // T3: RO write -> SLVERR, out-of-range -> DECERR
    do_write(8'h3C, 32'h1234_5678, 4'hF, SLVERR);
    @(posedge clk); #1;
    check("t3_no_pulse", 64'(wr_pulse), 0);
    wait_idle();
    do_read(8'h3C, 32'h3333_CCCC, OKAY);
    do_write(8'h40, 32'h1234_5678, 4'hF, DECERR);
    do_read(8'h40, 32'h0000_0000, DECERR);
    wait_idle();
    check("t3_reg1_kept", 64'(rw_regs[1*DW +: DW]), 64'hA5A5_1234);
    check("t3_reg2_kept", 64'(rw_regs[2*DW +: DW]), 64'h1122_33FF);

    // T4: B back-pressure blocks the next commit
    bus.S_AXI_BREADY = 1'b0;
    do_write(8'h0C, 32'hCAFE_0001, 4'hF, OKAY);
    do_write(8'h10, 32'h0BAD_0002, 4'hF, OKAY);
    repeat (5) begin
      @(negedge clk);
      check("t4_awready_low", 64'(bus.S_AXI_AWREADY), 0);
      check("t4_wready_low", 64'(bus.S_AXI_WREADY), 0);
      check("t4_bvalid_held", 64'(bus.S_AXI_BVALID), 1);
      check("t4_reg4_blocked", 64'(rw_regs[4*DW +: DW]), 0);
      @(posedge clk); #1;
    end
    bus.S_AXI_BREADY = 1'b1;
    wait_idle();
    check("t4_reg3", 64'(rw_regs[3*DW +: DW]), 64'hCAFE_0001);
    check("t4_reg4", 64'(rw_regs[4*DW +: DW]), 64'h0BAD_0002);
    // R back-pressure keeps the response stable
    bus.S_AXI_RREADY = 1'b0;
    do_read(8'h0C, 32'hCAFE_0001, OKAY);
    repeat (4) begin
      @(negedge clk);
      check("t4_rvalid_held", 64'(bus.S_AXI_RVALID), 1);
      check("t4_rdata_stable", 64'(bus.S_AXI_RDATA), 64'hCAFE_0001);
      check("t4_arready_low", 64'(bus.S_AXI_ARREADY), 0);
      @(posedge clk); #1;
    end
    bus.S_AXI_RREADY = 1'b1;
    wait_idle();

    // T5: reset with AW held and W not yet sent
    send_aw(8'h14);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_awready", 64'(bus.S_AXI_AWREADY), 1);
    check("t5_wready", 64'(bus.S_AXI_WREADY), 1);
    check("t5_bvalid", 64'(bus.S_AXI_BVALID), 0);
    check("t5_reg3_cleared", 64'(rw_regs[3*DW +: DW]), 0);
    @(posedge clk); #1;
    send_w(32'h0000_0055, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_commit", 64'(bus.S_AXI_BVALID), 0);
      @(posedge clk); #1;
    end
    check("t5_reg5_empty", 64'(rw_regs[5*DW +: DW]), 0);
    exp_b_q.push_back(OKAY);
    send_aw(8'h14);
    wait_idle();
    check("t5_reg5", 64'(rw_regs[5*DW +: DW]), 64'h0000_0055);

    // T6: RO read sampled at the AR handshake edge
    bus.S_AXI_RREADY = 1'b0;
    do_read(8'h30, 32'hDEAD_BEEF, OKAY);
    ro_status[31:0] = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1 bus.S_AXI_RREADY = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
